// File: rtl/output_streamer_if.sv
// output_streamer_if: raster pixel stream carrying all channels of one position per valid/ready transfer
interface output_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 32,
    parameter int WIDTH      = 13,
    parameter int HEIGHT     = 17
);
    logic                      valid_out;
    logic                      ready_in;
    logic [DATA_WIDTH-1:0]     data_out [0:CHANNELS-1];
    logic [$clog2(HEIGHT)-1:0] out_row;
    logic [$clog2(WIDTH)-1:0]  out_col;
    logic                      last_out;
    modport master (output valid_out, data_out, out_row, out_col, last_out, input ready_in);
    modport slave  (input valid_out, data_out, out_row, out_col, last_out, output ready_in);
endinterface

// File: rtl/output_streamer.sv
// output_streamer: replays a CHANNELS x HEIGHT x WIDTH frame as a raster stream; define FRAME_SHADOW_EN to capture the frame at load
module output_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 32,
    parameter int WIDTH      = 13,
    parameter int HEIGHT     = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] frame_in [0:CHANNELS-1][0:HEIGHT-1][0:WIDTH-1],
    output_streamer_if.master     s,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_d;
    logic                  data_en;
    logic [DATA_WIDTH-1:0] data_q [0:CHANNELS-1];
    logic [DATA_WIDTH-1:0] data_d [0:CHANNELS-1];

    // Next state: accept load only when idle, advance raster position on each transfer
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        data_en = 1'b0;
        if (state_q == IDLE) begin
            if (load) begin
                state_d = STREAM;
                row_d   = '0;
                col_d   = '0;
                valid_d = 1'b1;
                last_d  = (ROW_MAX == '0) && (COL_MAX == '0);
                data_en = 1'b1;
            end
        end else if (valid_q && s.ready_in) begin
            if (last_q) begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                col_d   = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
                row_d   = (col_q == COL_MAX) ? row_q + 1'b1 : row_q;
                last_d  = (row_d == ROW_MAX) && (col_d == COL_MAX);
                data_en = 1'b1;
            end
        end
    end

`ifdef FRAME_SHADOW_EN
    logic [DATA_WIDTH-1:0] shadow [0:CHANNELS-1][0:HEIGHT-1][0:WIDTH-1];

    // Snapshot the whole frame on an accepted load so upstream may overwrite frame_in
    always_ff @(posedge clk) begin
        if (state_q == IDLE && load) shadow <= frame_in;
    end

    // Element at the next position; the load cycle reads frame_in since the shadow fills on that edge
    always_comb begin
        for (int c = 0; c < CHANNELS; c++)
            data_d[c] = (state_q == IDLE) ? frame_in[c][0][0] : shadow[c][row_d][col_d];
    end
`else
    // Element at the next position, read straight from the held frame
    always_comb begin
        for (int c = 0; c < CHANNELS; c++)
            data_d[c] = (state_q == IDLE) ? frame_in[c][0][0] : frame_in[c][row_d][col_d];
    end
`endif

    // State, position and output registers; data only reloads when the position moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            frame_done <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) data_q[c] <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            frame_done <= done_d;
            if (data_en) data_q <= data_d;
        end
    end

    assign busy        = (state_q == STREAM);
    assign s.valid_out = valid_q;
    assign s.data_out  = data_q;
    assign s.out_row   = row_q;
    assign s.out_col   = col_q;
    assign s.last_out  = last_q;
endmodule

// File: doc/output_streamer.md
# output_streamer

Transmit-side counterpart to the layer input buffer. It takes one complete CHANNELS×HEIGHT×WIDTH feature-map frame and replays it as a raster-order stream, one pixel position per transfer, with all channels in parallel. The write order matches the input buffer: column fastest, then row. The block sits at a layer's output and feeds the next layer's input buffer, with valid/ready backpressure and a per-frame completion pulse.

## Interface
- DATA_WIDTH, 32, bits per element (fp32)
- CHANNELS, 32, parallel channels
- WIDTH, 13, columns per frame
- HEIGHT, 17, rows per frame
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; release is synchronous to clk
- load  in  1  request to start streaming the frame on frame_in
- frame_in  in  DATA_WIDTH × [0:CHANNELS-1][0:HEIGHT-1][0:WIDTH-1]  source frame
- ready_in  in  1  downstream can accept data this cycle
- valid_out  out  1  data_out holds a valid element
- data_out  out  DATA_WIDTH × [0:CHANNELS-1]  all channels at (out_row, out_col)
- out_row  out  $clog2(HEIGHT)  row index of data_out
- out_col  out  $clog2(WIDTH)  column index of data_out
- last_out  out  1  data_out is element (HEIGHT-1, WIDTH-1)
- busy  out  1  a frame is in flight
- frame_done  out  1  one-cycle pulse after the final transfer

## Operation
- The block has two states, IDLE and STREAM. Reset places it in IDLE.
- Load acceptance:
  - In IDLE, load=1 is accepted.
  - In STREAM, load is ignored with no side effect.
- On an accepted load:
  - State becomes STREAM and busy becomes 1.
  - row and col are set to 0.
  - data_out is registered with frame_in[c][0][0] for every channel c.
  - valid_out becomes 1.
- Transfer: a transfer occurs when valid_out && ready_in. On each transfer:
  - If col < WIDTH-1: col increments.
  - Otherwise: col wraps to 0 and row increments.
  - data_out reloads from the new (row, col).
- Final transfer (at row=HEIGHT-1, col=WIDTH-1):
  - State returns to IDLE.
  - valid_out, busy and last_out go to 0.
  - row and col go to 0.
  - frame_done goes to 1 for exactly one cycle.
- Backpressure: while valid_out && !ready_in, data_out, out_row, out_col and last_out hold stable.
- last_out = valid_out && row==HEIGHT-1 && col==WIDTH-1. It is registered together with data_out.
- Frame length is exactly HEIGHT×WIDTH transfers (221 at defaults). No partial frames exist.
- Behaviour while idle: data_out holds its last value and is don't-care while valid_out=0.
- Reset mid-frame: all state clears immediately (asynchronous), the frame is abandoned, and frame_done does not pulse.

## Timing
- Reset values: valid_out=0, data_out=0, out_row=0, out_col=0, last_out=0, busy=0, frame_done=0, state=IDLE.
- Load latency: load sampled at edge N gives valid_out=1 with element (0,0) after edge N, i.e. in cycle N+1.
- Throughput: one element per cycle while ready_in is held at 1.
- Frame duration: a full frame with ready_in=1 takes HEIGHT×WIDTH cycles of valid_out.
- frame_done: asserted in the cycle after the final transfer edge, with busy=0 in that same cycle.
- Back-to-back frames: load may be asserted in the frame_done cycle and is accepted there. The minimum gap between frames is one cycle of valid_out=0.
- ready_in may toggle arbitrarily and has no combinational path to any output.

## Configuration
- FRAME_SHADOW_EN defined:
  - On an accepted load, the entire frame_in is copied into an internal shadow array.
  - Streaming reads from the shadow array.
  - frame_in need only be valid in the load cycle, and upstream may overwrite it during STREAM.
- FRAME_SHADOW_EN undefined:
  - There is no shadow storage; data_out reloads directly from frame_in at (row, col).
  - frame_in must be held stable from the load cycle until frame_done.
  - Port list and timing are identical in both builds.

## Test plan
- Reset behaviour: assert rst_n=0 with load=1 and ready_in=1 → all outputs read 0. Release reset and pulse load → valid_out=1 next cycle with out_row=0, out_col=0.
- Full frame: frame_in[c][r][w] = c·1000 + r·16 + w; load, ready_in=1 constant → 221 transfers, in order, with matching values. Checks:
  - Row wraps after col=12.
  - last_out is high only on transfer 221, value c·1000 + 16·16 + 12.
  - frame_done pulses once in the next cycle.
- Backpressure: drive ready_in with a pseudo-random 50% pattern → data, indices and last_out are held while ready_in=0. Still 221 transfers, no duplicates or drops.
- Ignored load: assert load at transfer 100 → no restart, indices continue to (7,9), frame completes normally.
- Back-to-back frames: load in the frame_done cycle → valid_out=1 with (0,0) one cycle later. Second frame is correct.
- Reset mid-frame: assert rst_n=0 at transfer 50 → all outputs 0 immediately, no frame_done. A fresh load then streams from (0,0).
- Shadow build (FRAME_SHADOW_EN): change frame_in to all-ones after the load cycle → streamed data still equals the frame captured at load.
